// File: rtl/lock_key_pkg.sv
// Shared constants and FSM state type for the serial key loader of the locked c432 core.
// Optional parity stage is selected by LOCK_KEY_PARITY_EN (see lock_key_loader.sv).
package lock_key_pkg;
  localparam int XOR_W = 29;
  localparam int MUX_W = 4;
  localparam int KEY_W = XOR_W + MUX_W;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_PAR    = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } keyld_state_t;
endpackage

// File: rtl/keyld_shadow.sv
// Shadow key register, bit counter and (when LOCK_KEY_PARITY_EN is defined) running parity.
// Bits land LSB-first: the first accepted bit becomes shadow[0].
module keyld_shadow
  import lock_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             data_bit,
  output logic [KEY_W-1:0] shadow,
  output logic [CNT_W-1:0] count,
`ifdef LOCK_KEY_PARITY_EN
  output logic             parity,
`endif
  output logic             last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      count  <= '0;
    end else if (clear) begin
      shadow <= '0;
      count  <= '0;
    end else if (shift_en) begin
      shadow[count] <= data_bit;
      // Counter saturates on the last index; the FSM leaves SHIFT on that bit.
      if (count != LAST_IDX) count <= count + 1'b1;
    end
  end

`ifdef LOCK_KEY_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           parity <= 1'b0;
    else if (clear)    parity <= 1'b0;
    else if (shift_en) parity <= parity ^ data_bit;
  end
`endif

  assign last = (count == LAST_IDX);

endmodule

// File: rtl/lock_key_loader.sv
// Serial key loader: collects KEY_W bits over a valid/ready stream and commits them atomically.
// Define LOCK_KEY_PARITY_EN to append an even-parity bit per load and reject mismatching keys.
module lock_key_loader
  import lock_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  output logic             bit_ready_o,
  input  logic             lock_i,
  output logic [XOR_W-1:0] key_x_o,
  output logic [MUX_W-1:0] key_p_o,
  output logic             key_valid_o,
  output logic             busy_o,
  output logic             err_o,
  output keyld_state_t     state_o
);

  // Handshake: a bit transfers on a rising edge where bit_valid_i and bit_ready_o are both high;
  // bit_ready_o is high only in SHIFT/PAR, and a simultaneous start_i drops the bit.
  keyld_state_t     state;
  logic             lock_flag;
  logic             accept;
  logic             start_ok;
  logic             clear;
  logic             shift_en;
  logic [KEY_W-1:0] shadow;
  logic [CNT_W-1:0] count;
  logic             last;
`ifdef LOCK_KEY_PARITY_EN
  logic             parity;
`endif

  always_comb begin
    start_ok = 1'b0;
    case (state)
      S_IDLE, S_SHIFT, S_PAR, S_ERROR: start_ok = 1'b1;
      S_DONE:                          start_ok = ~lock_flag;
      default:                         start_ok = 1'b0;
    endcase
  end

  assign accept   = bit_valid_i & bit_ready_o & ~start_i;
  assign clear    = start_i & start_ok;
  assign shift_en = accept & (state == S_SHIFT);
  assign state_o  = state;

  keyld_shadow u_shadow (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift_en (shift_en),
    .data_bit (bit_i),
    .shadow   (shadow),
    .count    (count),
`ifdef LOCK_KEY_PARITY_EN
    .parity   (parity),
`endif
    .last     (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      key_x_o     <= '0;
      key_p_o     <= '0;
      key_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      bit_ready_o <= 1'b0;
      lock_flag   <= 1'b0;
    end else if (clear) begin
      state       <= S_SHIFT;
      busy_o      <= 1'b1;
      err_o       <= 1'b0;
      bit_ready_o <= 1'b1;
    end else begin
      case (state)
        S_SHIFT: begin
          if (accept && last) begin
`ifdef LOCK_KEY_PARITY_EN
            state       <= S_PAR;
`else
            state       <= S_COMMIT;
            bit_ready_o <= 1'b0;
`endif
          end
        end
`ifdef LOCK_KEY_PARITY_EN
        S_PAR: begin
          if (accept) begin
            bit_ready_o <= 1'b0;
            if (parity ^ bit_i) begin
              state  <= S_ERROR;
              busy_o <= 1'b0;
              err_o  <= 1'b1;
            end else begin
              state <= S_COMMIT;
            end
          end
        end
`endif
        S_COMMIT: begin
          key_x_o     <= shadow[XOR_W-1:0];
          key_p_o     <= shadow[KEY_W-1:XOR_W];
          key_valid_o <= 1'b1;
          lock_flag   <= lock_flag | lock_i;
          busy_o      <= 1'b0;
          state       <= S_DONE;
        end
        default: state <= state;
      endcase
    end
  end

  // count is only consumed through last; keep it observable to the hierarchy.
  logic unused_count;
  assign unused_count = ^count;

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader; covers both builds via LOCK_KEY_PARITY_EN.
module tb_lock_key_loader;
  import lock_key_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             bit_i = 1'b0;
  logic             bit_valid_i = 1'b0;
  logic             lock_i = 1'b0;
  logic             bit_ready_o;
  logic [XOR_W-1:0] key_x_o;
  logic [MUX_W-1:0] key_p_o;
  logic             key_valid_o;
  logic             busy_o;
  logic             err_o;
  keyld_state_t     state_o;

  int n_pass  = 0;
  int n_total = 0;

  lock_key_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .bit_i       (bit_i),
    .bit_valid_i (bit_valid_i),
    .bit_ready_o (bit_ready_o),
    .lock_i      (lock_i),
    .key_x_o     (key_x_o),
    .key_p_o     (key_p_o),
    .key_valid_o (key_valid_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_i       = b;
    bit_valid_i = 1'b1;
    step();
    bit_valid_i = 1'b0;
  endtask

  // Sends all KEY_W bits LSB-first, plus the parity bit when that build is selected.
  task automatic load_key(input logic [KEY_W-1:0] k, input logic good_par);
    for (int i = 0; i < KEY_W; i++) send_bit(k[i]);
`ifdef LOCK_KEY_PARITY_EN
    send_bit(good_par ? ^k : ~^k);
`else
    if (!good_par) bit_i = 1'b0;
`endif
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_key_x", key_x_o, 0);
    chk("rst_key_p", key_p_o, 0);
    chk("rst_valid", key_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", bit_ready_o, 0);
    rst = 1'b0;
    step();
    chk("idle_state", state_o, S_IDLE);

    // bit_valid_i outside SHIFT/PAR is ignored
    send_bit(1'b1);
    chk("idle_ignore_state", state_o, S_IDLE);
    chk("idle_ignore_ready", bit_ready_o, 0);

    // All-ones key
    do_start();
    chk("start_state", state_o, S_SHIFT);
    chk("start_ready", bit_ready_o, 1);
    chk("start_busy", busy_o, 1);
    load_key({KEY_W{1'b1}}, 1'b1);
    chk("ones_latency_valid", key_valid_o, 0);
    chk("ones_latency_state", state_o, S_COMMIT);
    chk("ones_commit_ready", bit_ready_o, 0);
    step();
    chk("ones_key_x", key_x_o, 29'h1FFFFFFF);
    chk("ones_key_p", key_p_o, 4'hF);
    chk("ones_valid", key_valid_o, 1);
    chk("ones_state", state_o, S_DONE);
    chk("ones_busy", busy_o, 0);

    // Reload 33'h1_2345_6789; previous key held during the load
    do_start();
    for (int i = 0; i < 12; i++) send_bit(1'b0);
    chk("reload_hold_x", key_x_o, 29'h1FFFFFFF);
    chk("reload_hold_valid", key_valid_o, 1);
    do_start();
    load_key(33'h1_2345_6789, 1'b1);
    chk("k2_latency_x", key_x_o, 29'h1FFFFFFF);
    step();
    chk("k2_key_x", key_x_o, 29'h03456789);
    chk("k2_key_p", key_p_o, 4'h9);
    chk("k2_valid", key_valid_o, 1);

`ifdef LOCK_KEY_PARITY_EN
    // Wrong parity: ERROR, outputs kept
    do_start();
    load_key(33'h0_A5A5_A5A5, 1'b0);
    chk("par_state", state_o, S_ERROR);
    chk("par_err", err_o, 1);
    chk("par_ready", bit_ready_o, 0);
    chk("par_keep_x", key_x_o, 29'h03456789);
    chk("par_keep_valid", key_valid_o, 1);
    step();
    chk("par_err_sticky", err_o, 1);
`endif

    // Restart after 10 bits, then restart again with a bit offered in the same cycle
    do_start();
    chk("restart_err_clear", err_o, 0);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    start_i     = 1'b1;
    bit_i       = 1'b1;
    bit_valid_i = 1'b1;
    step();
    start_i     = 1'b0;
    bit_valid_i = 1'b0;
    chk("restart_state", state_o, S_SHIFT);
    load_key(33'h0_A5A5_A5A5, 1'b1);
    step();
    chk("k3_key_x", key_x_o, 29'h05A5A5A5);
    chk("k3_key_p", key_p_o, 4'h5);
    chk("k3_err", err_o, 0);

    // Lock at commit; subsequent start refused
    lock_i = 1'b1;
    do_start();
    load_key(33'h1_0000_0001, 1'b1);
    step();
    lock_i = 1'b0;
    chk("k4_key_x", key_x_o, 29'h00000001);
    chk("k4_key_p", key_p_o, 4'h8);
    do_start();
    chk("lock_state", state_o, S_DONE);
    chk("lock_ready", bit_ready_o, 0);
    chk("lock_busy", busy_o, 0);
    step();
    chk("lock_key_x_held", key_x_o, 29'h00000001);

    // rst clears the lock
    #2 rst = 1'b1;
    #1;
    chk("lockrst_valid", key_valid_o, 0);
    chk("lockrst_key_x", key_x_o, 0);
    step();
    rst = 1'b0;
    step();
    do_start();
    chk("unlock_state", state_o, S_SHIFT);
    load_key({KEY_W{1'b1}}, 1'b1);
    step();
    chk("k5_valid", key_valid_o, 1);

    // Asynchronous reset mid-SHIFT after 20 bits
    do_start();
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_key_x", key_x_o, 0);
    chk("midrst_key_p", key_p_o, 0);
    chk("midrst_valid", key_valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", bit_ready_o, 0);
    chk("midrst_state", state_o, S_IDLE);
    step();
    rst = 1'b0;
    step();
    step();
    chk("postrst_ready", bit_ready_o, 0);
    do_start();
    chk("postrst_start_ready", bit_ready_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
